// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state type and defaults for the fetch sequencer
package pc_ctrl_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    RSP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pc_ctrl_fetch_buf.sv
// rtl/pc_ctrl_fetch_buf.sv - one-entry skid buffer holding a fetched instruction during decode stalls
module pc_ctrl_fetch_buf
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic            clr,
  output logic            full,
  output logic [XLEN-1:0] data
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (clr)        full <= 1'b0;
      else if (wr_en) full <= 1'b1;
      else if (rd_en) full <= 1'b0;
      if (wr_en && !clr) data <= wr_data;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch sequencer driving PC load/hold, imem handshake and IF/ID valid
// Optional trap entry point enabled with PC_CTRL_TRAP_EN.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef PC_CTRL_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_npc,
  output logic            pc_load,
  output logic            pc_hold,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic            flush_out
`ifdef PC_CTRL_TRAP_EN
  , input  logic            trap_valid,
  output logic [XLEN-1:0] trap_epc
`endif
);

  state_t          state;
  logic            buf_full;
  logic            buf_wr;
  logic            buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            kill;
  logic [XLEN-1:0] kill_target;

`ifdef PC_CTRL_TRAP_EN
  assign kill        = trap_valid || redirect_valid;
  assign kill_target = trap_valid ? TRAP_VEC : redirect_target;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           trap_epc <= '0;
    else if (trap_valid) trap_epc <= pc_cur;
  end
`else
  assign kill        = redirect_valid;
  assign kill_target = redirect_target;
`endif

  pc_ctrl_fetch_buf #(.XLEN(XLEN)) u_fetch_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (buf_wr),
    .wr_data (imem_rsp_data),
    .rd_en   (buf_rd),
    .clr     (kill),
    .full    (buf_full),
    .data    (buf_data)
  );

  // Redirect/trap act in the same cycle, so these strobes stay combinational.
  always_comb begin
    pc_npc         = '0;
    pc_load        = 1'b0;
    pc_hold        = 1'b1;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if_inst        = '0;
    flush_out      = 1'b0;
    buf_wr         = 1'b0;
    buf_rd         = 1'b0;
    if (!reset) begin
      if (kill) begin
        pc_load   = 1'b1;
        pc_hold   = 1'b0;
        pc_npc    = kill_target;
        flush_out = 1'b1;
      end else if (buf_full && !stall_in) begin
        if_valid = 1'b1;
        if_inst  = buf_data;
        pc_hold  = 1'b0;
        buf_rd   = 1'b1;
      end else begin
        case (state)
          REQ: imem_req_valid = !buf_full;
          RSP: begin
            if (imem_rsp_valid) begin
              if (!stall_in) begin
                if_valid = 1'b1;
                if_inst  = imem_rsp_data;
                pc_hold  = 1'b0;
              end else begin
                buf_wr = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A response always returns to REQ; a kill while still waiting turns it stale.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: if (imem_req_valid && imem_req_ready) state <= RSP;
        RSP: begin
          if (imem_rsp_valid) state <= REQ;
          else if (kill)      state <= DRAIN;
        end
        DRAIN: if (imem_rsp_valid) state <= REQ;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
